// File: rtl/wb_pipe_buf_if.sv
// wb_pipe_buf_if: bus bundle for the writeback pipeline register.
// Signal names are seen from the buffer's side (_i into the buffer, _o out of it).
//   flush_i                          : drop all buffered entries
//   in_valid_i / in_ready_o          : upstream (memory stage) handshake
//   in_rd_addr_i, in_rd_wr_en_i,
//   in_rd_wr_data_i                  : upstream entry
//   out_valid_o / out_ready_i        : downstream (register-file port) handshake
//   rd_addr_o, rd_wr_en_o,
//   rd_wr_data_o                     : head entry
//   fwd_rs{1,2}_*                    : decode-stage forwarding lookups, present
//                                      only when WB_FWD_EN is defined
// Modports: slave = the buffer, master = the surrounding pipeline.
interface wb_pipe_buf_if #(
  parameter int XLEN = 32,
  parameter int REGN = 5
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [REGN-1:0] in_rd_addr_i;
  logic            in_rd_wr_en_i;
  logic [XLEN-1:0] in_rd_wr_data_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [REGN-1:0] rd_addr_o;
  logic            rd_wr_en_o;
  logic [XLEN-1:0] rd_wr_data_o;
`ifdef WB_FWD_EN
  logic [REGN-1:0] fwd_rs1_addr_i;
  logic [REGN-1:0] fwd_rs2_addr_i;
  logic            fwd_rs1_hit_o;
  logic            fwd_rs2_hit_o;
  logic [XLEN-1:0] fwd_rs1_data_o;
  logic [XLEN-1:0] fwd_rs2_data_o;
`endif

  modport slave (
    input  flush_i, in_valid_i, in_rd_addr_i, in_rd_wr_en_i, in_rd_wr_data_i, out_ready_i,
`ifdef WB_FWD_EN
    input  fwd_rs1_addr_i, fwd_rs2_addr_i,
    output fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_rs1_data_o, fwd_rs2_data_o,
`endif
    output in_ready_o, out_valid_o, rd_addr_o, rd_wr_en_o, rd_wr_data_o
  );

  modport master (
    output flush_i, in_valid_i, in_rd_addr_i, in_rd_wr_en_i, in_rd_wr_data_i, out_ready_i,
`ifdef WB_FWD_EN
    output fwd_rs1_addr_i, fwd_rs2_addr_i,
    input  fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_rs1_data_o, fwd_rs2_data_o,
`endif
    input  in_ready_o, out_valid_o, rd_addr_o, rd_wr_en_o, rd_wr_data_o
  );
endinterface

// File: rtl/wb_pipe_buf.sv
// wb_pipe_buf: writeback pipeline register with a two-entry skid buffer.
// Carries rd address / write enable / write data from the memory stage to the
// register-file write port. in_ready_o comes straight from a flop, so there is
// no combinational path from out_ready_i back to the memory stage.
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : synchronous active-low reset
//   bus      : wb_pipe_buf_if.slave (handshakes, entry fields, flush, fwd)
// Optional feature macro: WB_FWD_EN adds combinational forwarding lookups.
module wb_pipe_buf #(
  parameter int XLEN = 32,
  parameter int REGN = 5
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  wb_pipe_buf_if.slave bus
);
  typedef struct packed {
    logic [REGN-1:0] addr;
    logic            wr_en;
    logic [XLEN-1:0] data;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e state_q;
  ent_t   head_q, skid_q, in_e;
  logic   in_ready_q;
  logic   accept, pop;

  // Writes to x0 are neutralised at capture; address and data pass unchanged.
  assign in_e.addr  = bus.in_rd_addr_i;
  assign in_e.wr_en = bus.in_rd_wr_en_i & (|bus.in_rd_addr_i);
  assign in_e.data  = bus.in_rd_wr_data_i;

  assign accept = bus.in_valid_i & in_ready_q;
  assign pop    = (state_q != EMPTY) & bus.out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
    end else if (bus.flush_i) begin
      // Data/address regs hold; only validity and write enables are killed.
      state_q      <= EMPTY;
      in_ready_q   <= 1'b1;
      head_q.wr_en <= 1'b0;
      skid_q.wr_en <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          head_q  <= in_e;
          state_q <= ONE;
        end
        ONE: begin
          if (accept && pop) begin
            head_q <= in_e;
          end else if (accept) begin
            skid_q     <= in_e;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: if (pop) begin
          head_q     <= skid_q;
          state_q    <= ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready_o   = in_ready_q;
  assign bus.out_valid_o  = (state_q != EMPTY);
  assign bus.rd_addr_o    = head_q.addr;
  assign bus.rd_wr_en_o   = head_q.wr_en;
  assign bus.rd_wr_data_o = head_q.data;

`ifdef WB_FWD_EN
  logic head_live, skid_live;
  assign head_live = (state_q != EMPTY) & head_q.wr_en;
  assign skid_live = (state_q == FULL)  & skid_q.wr_en;

  // Skid holds the younger entry, so it wins when both match.
  function automatic logic [XLEN:0] lookup(input logic [REGN-1:0] a,
                                           input logic hl, input logic sl,
                                           input ent_t h, input ent_t s);
    logic [XLEN:0] r;
    r = '0;
    if (a != '0) begin
      if (sl && s.addr == a)      r = {1'b1, s.data};
      else if (hl && h.addr == a) r = {1'b1, h.data};
    end
    return r;
  endfunction

  logic [XLEN:0] lk1, lk2;
  assign lk1 = lookup(bus.fwd_rs1_addr_i, head_live, skid_live, head_q, skid_q);
  assign lk2 = lookup(bus.fwd_rs2_addr_i, head_live, skid_live, head_q, skid_q);
  assign bus.fwd_rs1_hit_o  = lk1[XLEN];
  assign bus.fwd_rs1_data_o = lk1[XLEN-1:0];
  assign bus.fwd_rs2_hit_o  = lk2[XLEN];
  assign bus.fwd_rs2_data_o = lk2[XLEN-1:0];
`endif
endmodule

// File: tb/tb_wb_pipe_buf.sv
// tb_wb_pipe_buf: self-checking bench for wb_pipe_buf. The reference model is a
// plain queue of at most two entries; outputs are sampled on the falling edge.
module tb_wb_pipe_buf;
  localparam int XLEN = 32;
  localparam int REGN = 5;

  typedef struct {
    logic [REGN-1:0] addr;
    logic            wr_en;
    logic [XLEN-1:0] data;
  } ment_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  ment_t q[$];

  always #5 clk = ~clk;

  wb_pipe_buf_if #(.XLEN(XLEN), .REGN(REGN)) bus();
  wb_pipe_buf #(.XLEN(XLEN), .REGN(REGN)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  // Drive one cycle of inputs (called at a falling edge), advance the model at
  // the rising edge, return at the next falling edge. acc reports an accept.
  task automatic step(input logic v, input logic [REGN-1:0] a, input logic we,
                      input logic [XLEN-1:0] d, input logic ordy,
                      input logic fl, input logic rst, output logic acc);
    logic p;
    ment_t e;
    bus.in_valid_i      = v;
    bus.in_rd_addr_i    = a;
    bus.in_rd_wr_en_i   = we;
    bus.in_rd_wr_data_i = d;
    bus.out_ready_i     = ordy;
    bus.flush_i         = fl;
    rst_n               = rst;
    acc = rst && !fl && v && (q.size() < 2);
    p   = rst && !fl && ordy && (q.size() > 0);
    e.addr = a; e.wr_en = we && (a != 0); e.data = d;
    @(posedge clk);
    if (!rst || fl) q.delete();
    else begin
      if (p) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, '0, 1'b0, '0, ordy, 1'b0, 1'b1, acc);
  endtask

  task automatic send(input logic [REGN-1:0] a, input logic [XLEN-1:0] d, input logic ordy);
    logic acc;
    step(1'b1, a, 1'b1, d, ordy, 1'b0, 1'b1, acc);
  endtask

  task automatic test_reset;
    logic acc;
    step(1'b1, 5'd7, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    total += 5;
    if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid_o); end
    if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready_o); end
    if (bus.rd_addr_o !== '0) begin bad++; $display("FAIL reset_rd_addr got=%h exp=0", bus.rd_addr_o); end
    if (bus.rd_wr_en_o !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", bus.rd_wr_en_o); end
    if (bus.rd_wr_data_o !== '0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", bus.rd_wr_data_o); end
  endtask

  task automatic test_basic;
    // First edge out of reset already accepts.
    send(5'd5, 32'hDEADBEEF, 1'b1);
    total += 5;
    if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid_o); end
    if (bus.rd_addr_o !== 5'd5) begin bad++; $display("FAIL basic_addr got=%h exp=5", bus.rd_addr_o); end
    if (bus.rd_wr_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_data got=%h exp=deadbeef", bus.rd_wr_data_o); end
    if (bus.rd_wr_en_o !== 1'b1) begin bad++; $display("FAIL basic_wr_en got=%b exp=1", bus.rd_wr_en_o); end
    if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b exp=1", bus.in_ready_o); end
    idle(1'b1);
    total++;
    if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", bus.out_valid_o); end
  endtask

  task automatic test_backpressure;
    send(5'd1, 32'h11, 1'b0);
    total++;
    if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b exp=1", bus.in_ready_o); end
    send(5'd2, 32'h22, 1'b0);
    total += 3;
    if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", bus.in_ready_o); end
    if (bus.rd_wr_data_o !== 32'h11) begin bad++; $display("FAIL bp_head_a got=%h exp=11", bus.rd_wr_data_o); end
    if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", bus.out_valid_o); end
    idle(1'b0);
    total++;
    if (bus.rd_wr_data_o !== 32'h11) begin bad++; $display("FAIL bp_hold got=%h exp=11", bus.rd_wr_data_o); end
    idle(1'b1);
    total += 3;
    if (bus.rd_wr_data_o !== 32'h22) begin bad++; $display("FAIL bp_head_b got=%h exp=22", bus.rd_wr_data_o); end
    if (bus.rd_addr_o !== 5'd2) begin bad++; $display("FAIL bp_addr_b got=%h exp=2", bus.rd_addr_o); end
    if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", bus.in_ready_o); end
    idle(1'b1);
    total++;
    if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid_o); end
  endtask

  task automatic test_flush;
    logic acc;
    send(5'd9, 32'h99, 1'b0);
    send(5'd10, 32'hAA, 1'b0);
    step(1'b1, 5'd11, 1'b1, 32'hBB, 1'b1, 1'b1, 1'b1, acc);
    total += 2;
    if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid_o); end
    if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", bus.in_ready_o); end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      total++;
      if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_ghost cyc=%0d got=%b exp=0", i, bus.out_valid_o); end
    end
  endtask

  task automatic test_x0;
    send(5'd0, 32'h5, 1'b0);
    total += 4;
    if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL x0_valid got=%b exp=1", bus.out_valid_o); end
    if (bus.rd_wr_en_o !== 1'b0) begin bad++; $display("FAIL x0_wr_en got=%b exp=0", bus.rd_wr_en_o); end
    if (bus.rd_addr_o !== 5'd0) begin bad++; $display("FAIL x0_addr got=%h exp=0", bus.rd_addr_o); end
    if (bus.rd_wr_data_o !== 32'h5) begin bad++; $display("FAIL x0_data got=%h exp=5", bus.rd_wr_data_o); end
    idle(1'b1);
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd;
    logic acc;
    send(5'd3, 32'hA, 1'b0);
    send(5'd3, 32'hB, 1'b0);
    bus.fwd_rs1_addr_i = 5'd3;
    bus.fwd_rs2_addr_i = 5'd0;
    #1;
    total += 4;
    if (bus.fwd_rs1_hit_o !== 1'b1) begin bad++; $display("FAIL fwd_rs1_hit got=%b exp=1", bus.fwd_rs1_hit_o); end
    if (bus.fwd_rs1_data_o !== 32'hB) begin bad++; $display("FAIL fwd_rs1_data got=%h exp=b", bus.fwd_rs1_data_o); end
    if (bus.fwd_rs2_hit_o !== 1'b0) begin bad++; $display("FAIL fwd_rs2_hit got=%b exp=0", bus.fwd_rs2_hit_o); end
    if (bus.fwd_rs2_data_o !== '0) begin bad++; $display("FAIL fwd_rs2_data got=%h exp=0", bus.fwd_rs2_data_o); end
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
    total++;
    if (bus.fwd_rs1_hit_o !== 1'b0) begin bad++; $display("FAIL fwd_flush_hit got=%b exp=0", bus.fwd_rs1_hit_o); end
    bus.fwd_rs1_addr_i = '0;
  endtask
`endif

  task automatic test_stream;
    int seq = 0, last = -1, cyc = 0;
    logic acc, v, ordy, rst, popping;
    logic [REGN-1:0] a;
    while (seq < 100 && cyc < 3000) begin
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      rst  = ($urandom_range(0, 29) != 0);
      a    = REGN'($urandom);
      popping = rst && ordy && bus.out_valid_o;
      // Each popped entry must carry a strictly newer sequence number.
      if (popping) begin
        total++;
        if (int'(bus.rd_wr_data_o[15:0]) <= last) begin
          bad++; $display("FAIL stream_order got=%0d last=%0d", bus.rd_wr_data_o[15:0], last);
        end
        last = int'(bus.rd_wr_data_o[15:0]);
      end
      step(v, a, 1'b1, {16'hC0DE, 16'(seq)}, ordy, 1'b0, rst, acc);
      if (acc) seq++;
      cyc++;
      total += 2;
      if (bus.out_valid_o !== (q.size() > 0)) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid_o, q.size() > 0); end
      if (bus.in_ready_o !== (q.size() < 2)) begin bad++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready_o, q.size() < 2); end
      if (q.size() > 0) begin
        total++;
        if (bus.rd_addr_o !== q[0].addr || bus.rd_wr_en_o !== q[0].wr_en || bus.rd_wr_data_o !== q[0].data) begin
          bad++;
          $display("FAIL stream_head cyc=%0d got=%h/%b/%h exp=%h/%b/%h", cyc, bus.rd_addr_o,
                   bus.rd_wr_en_o, bus.rd_wr_data_o, q[0].addr, q[0].wr_en, q[0].data);
        end
      end
    end
    total++;
    if (seq < 100) begin bad++; $display("FAIL stream_budget got=%0d exp=100", seq); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.in_rd_addr_i = '0;
    bus.in_rd_wr_en_i = 1'b0; bus.in_rd_wr_data_i = '0; bus.out_ready_i = 1'b0;
`ifdef WB_FWD_EN
    bus.fwd_rs1_addr_i = '0; bus.fwd_rs2_addr_i = '0;
`endif
    @(negedge clk);
    test_reset;
    test_basic;
    test_backpressure;
    test_flush;
    test_x0;
`ifdef WB_FWD_EN
    test_fwd;
`endif
    test_stream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_pipe_buf.md
# wb_pipe_buf

Parametrised writeback pipeline register with a two-entry skid buffer. It carries the rd address, write enable and write data from the memory stage to the register-file write port. It uses a valid/ready handshake, so a stalled register-file port back-pressures the memory stage without a combinational ready path. It supports a synchronous flush, and optionally provides forwarding lookups for the decode stage.

## Interface
Parameters:
- XLEN, 32, data width of rd write data
- REGN, 5, width of the rd register address

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  reset; one clock; reset is synchronous and active-low
- flush_i  in  1  discard all buffered entries
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  buffer can accept an entry; registered
- in_rd_addr_i  in  REGN  destination register
- in_rd_wr_en_i  in  1  entry writes the register file
- in_rd_wr_data_i  in  XLEN  write data
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  register-file port accepts the head
- rd_addr_o  out  REGN  head destination
- rd_wr_en_o  out  1  head write enable
- rd_wr_data_o  out  XLEN  head write data
- fwd_rs1_addr_i, fwd_rs2_addr_i  in  REGN  lookup addresses (WB_FWD_EN only)
- fwd_rs1_hit_o, fwd_rs2_hit_o  out  1  lookup hit (WB_FWD_EN only)
- fwd_rs1_data_o, fwd_rs2_data_o  out  XLEN  forwarded data (WB_FWD_EN only)

## Operation
- Storage: a head register (drives the out_* ports) and a skid register. States: EMPTY (neither valid), ONE (head valid), FULL (both valid).
- Accept = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
- in_ready_o = 1 in EMPTY and ONE, 0 in FULL. It depends only on registered state.
- Transitions from EMPTY:
  - accept → ONE, with the entry loaded into the head.
- Transitions from ONE:
  - accept & pop → ONE, with the new entry loaded into the head.
  - accept & !pop → FULL, with the new entry loaded into the skid register.
  - pop & !accept → EMPTY.
- Transitions from FULL (no accept is possible):
  - pop → ONE, with the skid entry moved to the head.
- Entry ordering is strictly FIFO.
- x0 rule: an entry with in_rd_addr_i == 0 is stored with wr_en = 0. Address and data are stored unchanged.
- Flush:
  - Next state is EMPTY; both valids and both stored wr_en bits are cleared.
  - Flush overrides an accept or pop in the same cycle; the accepted entry is dropped.
  - Data and address registers hold their values.
- Reset:
  - All outputs are 0, except in_ready_o = 1.
  - A reset asserted mid-operation drops every buffered entry.

## Timing
- Latency: an entry accepted at edge N appears on out_* after edge N (1 cycle) when the buffer was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput: 1 entry per cycle while out_ready_i = 1.
- out_* hold stable while out_valid_o = 1 and out_ready_i = 0.
- in_ready_o deasserts the cycle after entering FULL and reasserts the cycle after the pop from FULL.
- The first edge with rst_n_i = 1 may already accept an entry.

## Configuration
- WB_FWD_EN defined: the forwarding lookups are combinational.
  - Hit = a valid entry with wr_en = 1, a matching address, and a nonzero lookup address.
  - The skid entry (younger) has priority over the head.
  - On a miss the data output is 0.
  - Flush clears hits in the cycle after the flush edge.
- WB_FWD_EN undefined: the fwd_* ports are absent and no comparators are built.

## Test plan
- Reset, then accept addr 5 / data 0xDEADBEEF / wr_en 1 with out_ready_i = 1 → out_valid_o = 1, rd_addr_o = 5, rd_wr_data_o = 0xDEADBEEF one cycle later, and in_ready_o stays 1.
- out_ready_i = 0, send A = 0x11, then B = 0x22 → in_ready_o = 0 after B. Raise out_ready_i → A then B in order, and in_ready_o returns to 1.
- FULL state with flush_i = 1 and in_valid_i = 1 in the same cycle → next cycle out_valid_o = 0 and in_ready_o = 1; no entry ever emerges.
- Accept addr 0 with wr_en 1 and data 0x5 → rd_wr_en_o = 0, rd_addr_o = 0, rd_wr_data_o = 0x5.
- WB_FWD_EN: head holds r3 = 0xA and skid holds r3 = 0xB, with fwd_rs1_addr_i = 3 → hit = 1, data = 0xB. With fwd_rs2_addr_i = 0 → hit = 0, data = 0.
- Stream 100 random entries with random out_ready_i and sporadic mid-stream rst_n_i pulses → the output sequence equals the input sequence minus the dropped entries; no duplicates and no reordering.
